// File: rtl/alu_pwr_seq.sv
// rtl/alu_pwr_seq.sv - power-down/power-up sequencer for the ALU power domain
module alu_pwr_seq #(
  parameter int unsigned SAVE_CYCLES    = 2,
  parameter int unsigned ISO_CYCLES     = 2,
  parameter int unsigned RAMP_CYCLES    = 4,
  parameter int unsigned RESTORE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       alu_busy,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       pd_off,
  output logic       seq_busy,
  output logic [2:0] pwr_state,
  output logic [7:0] off_count
);

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_SAVE    = 3'd1,
    ST_ISO     = 3'd2,
    ST_OFF     = 3'd3,
    ST_PWR_UP  = 3'd4,
    ST_RESTORE = 3'd5
  } state_t;

  localparam logic [7:0] SAVE_LAST    = 8'(SAVE_CYCLES - 1);
  localparam logic [7:0] ISO_LAST     = 8'(ISO_CYCLES - 1);
  localparam logic [7:0] RAMP_LAST    = 8'(RAMP_CYCLES - 1);
  localparam logic [7:0] RESTORE_LAST = 8'(RESTORE_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] dwell;
  logic       nxt_pwr_en;
  logic       nxt_iso;
  logic       nxt_save;
  logic       nxt_restore;

  // State register, dwell counter and OFF-entry counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ON;
      dwell     <= 8'd0;
      off_count <= 8'd0;
    end else begin
      state <= next_state;
      if (next_state != state || state == ST_ON || state == ST_OFF)
        dwell <= 8'd0;
      else
        dwell <= dwell + 8'd1;
      if (state == ST_ISO && next_state == ST_OFF && off_count != 8'hFF)
        off_count <= off_count + 8'd1;
    end
  end

  // Request is only looked at in ON and OFF; timed states always run to completion
  always_comb begin
    next_state = state;
    case (state)
      ST_ON:      if (sleep_req && !alu_busy)  next_state = ST_SAVE;
      ST_SAVE:    if (dwell == SAVE_LAST)      next_state = ST_ISO;
      ST_ISO:     if (dwell == ISO_LAST)       next_state = ST_OFF;
      ST_OFF:     if (!sleep_req)              next_state = ST_PWR_UP;
      ST_PWR_UP:  if (dwell == RAMP_LAST)      next_state = ST_RESTORE;
      ST_RESTORE: if (dwell == RESTORE_LAST)   next_state = ST_ON;
      default:                                 next_state = ST_ON;
    endcase
  end

  always_comb begin
    nxt_pwr_en  = 1'b1;
    nxt_iso     = 1'b0;
    nxt_save    = 1'b0;
    nxt_restore = 1'b0;
    case (next_state)
      ST_SAVE:    nxt_save = 1'b1;
      ST_ISO:     nxt_iso  = 1'b1;
      ST_OFF: begin
        nxt_pwr_en = 1'b0;
        nxt_iso    = 1'b1;
      end
      ST_PWR_UP:  nxt_iso  = 1'b1;
      ST_RESTORE: begin
        nxt_iso     = 1'b1;
        nxt_restore = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet track state exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_pwr_en <= 1'b1;
      iso_en     <= 1'b0;
      save       <= 1'b0;
      restore    <= 1'b0;
      pd_off     <= 1'b0;
      seq_busy   <= 1'b0;
      pwr_state  <= 3'd0;
    end else begin
      alu_pwr_en <= nxt_pwr_en;
      iso_en     <= nxt_iso;
      save       <= nxt_save;
      restore    <= nxt_restore;
      pd_off     <= (next_state == ST_OFF);
      seq_busy   <= (next_state != ST_ON) && (next_state != ST_OFF);
      pwr_state  <= next_state;
    end
  end

endmodule

// File: doc/alu_pwr_seq.md
Name: alu_pwr_seq

Overview:
- Power-management sequencer that drives the power-control interface of the ALU power domain (PD_ALU): alu_pwr_en, iso_en, save, restore.
- Converts a single level request, sleep_req, into an ordered power-down sequence: drain, save, isolate, power off.
- Converts the release of sleep_req into the reverse power-up sequence: power on, ramp, restore, de-isolate.
- Lives in PD_AON beside the always-on block and feeds the same control inputs the ALU consumes.

Parameters:
- SAVE_CYCLES, 2, cycles save is held high; legal range 1..255.
- ISO_CYCLES, 2, cycles isolation is held before power is removed; legal range 1..255.
- RAMP_CYCLES, 4, cycles after alu_pwr_en rises before restore; legal range 1..255.
- RESTORE_CYCLES, 2, cycles restore is held high; legal range 1..255.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset; synchronous, active-high.
- sleep_req  input  1  level; 1 = ALU domain should be off, 0 = ALU domain should be on.
- alu_busy  input  1  ALU busy flag; blocks power-down while 1.
- alu_pwr_en  output  1  ALU domain power switch enable.
- iso_en  output  1  ALU output isolation enable.
- save  output  1  retention save strobe.
- restore  output  1  retention restore strobe.
- pd_off  output  1  1 only in state OFF.
- seq_busy  output  1  1 in any state except ON and OFF.
- pwr_state  output  3  encoding: ON=0, SAVE=1, ISO=2, OFF=3, PWR_UP=4, RESTORE=5.
- off_count  output  8  number of entries into OFF; saturates at 255.

Behaviour:
- All outputs are registered and are a function of the current state only.
- Reset is synchronous; when rst=1 at a clk edge:
  - state goes to ON and the 8-bit dwell counter clears;
  - alu_pwr_en=1, iso_en=0, save=0, restore=0, pd_off=0, seq_busy=0, pwr_state=0, off_count=0.
  - Reset has the same effect from any state. Reset from OFF re-powers the domain with no restore pulse; this is accepted.
- Output values per state (alu_pwr_en, iso_en, save, restore):
  - ON: 1, 0, 0, 0
  - SAVE: 1, 0, 1, 0
  - ISO: 1, 1, 0, 0
  - OFF: 0, 1, 0, 0
  - PWR_UP: 1, 1, 0, 0
  - RESTORE: 1, 1, 0, 1
- Dwell counter:
  - loads 0 on entry to each timed state and increments every cycle in that state;
  - the state exits on the edge where counter == N-1, so the state lasts exactly N cycles.
- Transitions:
  - ON -> SAVE when sleep_req=1 and alu_busy=0. While alu_busy=1, stay in ON indefinitely; there is no timeout.
  - SAVE -> ISO after SAVE_CYCLES.
  - ISO -> OFF after ISO_CYCLES; off_count increments on this edge unless it is already 255.
  - OFF -> PWR_UP when sleep_req=0.
  - PWR_UP -> RESTORE after RAMP_CYCLES.
  - RESTORE -> ON after RESTORE_CYCLES.
- sleep_req is sampled only in ON and OFF.
  - A change during SAVE, ISO, PWR_UP or RESTORE never aborts a sequence.
  - A request dropped mid power-down completes to OFF; OFF then lasts exactly 1 cycle before PWR_UP.
  - A request raised mid power-up completes to ON; ON then lasts exactly 1 cycle before SAVE, provided alu_busy=0.
- Invariants checked by the bench:
  - save and restore are never high together.
  - alu_pwr_en=0 implies iso_en=1.
  - iso_en rises only while save=0.
  - iso_en falls only on entry to ON.

Test Plan:
1. Reset, then sleep_req=1 and alu_busy=0 sampled at edge 0 -> save=1 for edges 0..1; iso_en=1 from edge 2; alu_pwr_en=0 and pd_off=1 from edge 4; off_count=1.
2. From OFF, sleep_req=0 sampled at edge W -> alu_pwr_en=1 at W; restore=1 at W+4..W+5; iso_en=0, pwr_state=0, seq_busy=0 at W+6.
3. sleep_req=1 with alu_busy=1 for 20 cycles, then alu_busy=0 -> stays in ON with save=0 for all 20 cycles; SAVE entered on the first edge where alu_busy=0 is sampled.
4. sleep_req pulses for 1 cycle -> full power-down to OFF; OFF lasts exactly 1 cycle; PWR_UP at edge 5; back to ON at edge 11.
5. rst=1 during RESTORE, and separately during OFF -> next edge: ON with alu_pwr_en=1, iso_en=0, restore=0, off_count=0.
6. 256 full sleep/wake cycles -> off_count saturates at 255; the invariants hold in every cycle throughout.
